// File: rtl/cordic_pkg.sv
// Shared constants, quadrant code type and Q16 scaling helper for the
// full-circle CORDIC arctangent wrapper.
package cordic_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int EXPAND_BIT_DEF = 16;
    localparam int PI_Q           = 205887;
    localparam int TWO_PI_Q       = 411775;

    typedef enum logic [1:0] {
        QC_ZERO = 2'b00,
        QC_POS  = 2'b01,
        QC_NEG  = 2'b11
    } qcode_t;

    // PI_Q/TWO_PI_Q are Q16 values; rescale them when EXPAND_BIT differs.
    function automatic longint scale_q16(input longint value, input int frac_bits);
        longint result;
        if (frac_bits >= 16) begin
            result = value <<< (frac_bits - 16);
        end else begin
            result = value >>> (16 - frac_bits);
        end
        return result;
    endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Show-ahead synchronous result buffer; head entry is presented while o_valid.
module cordic_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nx;
    logic             r_valid;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    always_comb begin
        w_do_push = i_push && (r_count != CW'(DEPTH));
        w_do_pop  = i_pop && r_valid;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nx = r_count + CW'(1);
            2'b01:   w_count_nx = r_count - CW'(1);
            default: w_count_nx = r_count;
        endcase
    end

    // Non-empty flag is registered from the next count so o_valid is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nx;
            r_valid <= (w_count_nx != '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/cordic_atan_quad.sv
// Extends a right-half-plane CORDIC arctangent core to the full circle:
// folds inputs, tracks quadrant alongside the core, corrects and buffers results.
module cordic_atan_quad
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int EXPAND_BIT     = EXPAND_BIT_DEF,
    parameter int CORDIC_LATENCY = 6,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    output logic [DATA_WIDTH-1:0] core_x,
    output logic [DATA_WIDTH-1:0] core_y,
    input  logic [DATA_WIDTH-1:0] core_atan,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_angle
);

    localparam int L  = CORDIC_LATENCY;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [DATA_WIDTH:0] PI_W     = (DATA_WIDTH+1)'(scale_q16(longint'(PI_Q), EXPAND_BIT));
    localparam logic signed [DATA_WIDTH:0] TWO_PI_W = (DATA_WIDTH+1)'(scale_q16(longint'(TWO_PI_Q), EXPAND_BIT));
    localparam logic signed [DATA_WIDTH:0] NEG_PI_W = -PI_W;

    logic [L:0]                   r_sr_vld;
    logic [L:0]                   r_sr_zero;
    qcode_t                       r_sr_code [L+1];
    logic                         r_run;
    logic                         w_accept;
    logic                         w_zero;
    logic                         w_push;
    qcode_t                       w_code;
    logic [DATA_WIDTH-1:0]        w_fold_x;
    logic [DATA_WIDTH-1:0]        w_fold_y;
    logic [DATA_WIDTH-1:0]        w_result;
    logic signed [DATA_WIDTH:0]   w_atan_ext;
    logic signed [DATA_WIDTH:0]   w_corr;
    logic signed [DATA_WIDTH:0]   w_wrap;
    logic [CW:0]                  w_inflight;
    logic [CW:0]                  w_credit;
    logic [CW-1:0]                w_fifo_count;

    // Left-half-plane vectors are rotated by pi so the core only sees x >= 0.
    always_comb begin
        w_zero = (x_in == '0) && (y_in == '0);
        if (x_in[DATA_WIDTH-1]) begin
            w_fold_x = -x_in;
            w_fold_y = -y_in;
            w_code   = y_in[DATA_WIDTH-1] ? QC_NEG : QC_POS;
        end else begin
            w_fold_x = x_in;
            w_fold_y = y_in;
            w_code   = QC_ZERO;
        end
    end

    // Every accepted pair already owns a FIFO slot, so the core never stalls.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= L; i++) begin
            w_inflight = w_inflight + (CW+1)'(r_sr_vld[i]);
        end
        w_credit = w_inflight + {1'b0, w_fifo_count};
        in_ready = r_run && (w_credit < (CW+1)'(FIFO_DEPTH));
        w_accept = in_valid && in_ready;
    end

    always_comb begin
        w_atan_ext = {core_atan[DATA_WIDTH-1], core_atan};
        case (r_sr_code[L])
            QC_POS:  w_corr = w_atan_ext + PI_W;
            QC_NEG:  w_corr = w_atan_ext - PI_W;
            default: w_corr = w_atan_ext;
        endcase
        // Wrap into (-pi, pi]: exactly pi is kept, exactly -pi becomes +pi.
        if (w_corr > PI_W) begin
            w_wrap = w_corr - TWO_PI_W;
        end else if (w_corr <= NEG_PI_W) begin
            w_wrap = w_corr + TWO_PI_W;
        end else begin
            w_wrap = w_corr;
        end
        if (r_sr_zero[L]) begin
            w_result = '0;
        end else begin
            w_result = w_wrap[DATA_WIDTH-1:0];
        end
        w_push = r_sr_vld[L];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            core_x    <= '0;
            core_y    <= '0;
            r_sr_vld  <= '0;
            r_sr_zero <= '0;
            for (int i = 0; i <= L; i++) begin
                r_sr_code[i] <= QC_ZERO;
            end
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                core_x <= w_fold_x;
                core_y <= w_fold_y;
            end
            r_sr_vld     <= {r_sr_vld[L-1:0], w_accept};
            r_sr_zero    <= {r_sr_zero[L-1:0], w_accept && w_zero};
            r_sr_code[0] <= w_code;
            for (int i = 1; i <= L; i++) begin
                r_sr_code[i] <= r_sr_code[i-1];
            end
        end
    end

    cordic_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_result),
        .i_pop   (out_valid && out_ready),
        .o_data  (out_angle),
        .o_valid (out_valid),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_cordic_atan_quad.sv
// Directed bench for cordic_atan_quad with an ideal fixed-latency atan core model.
module tb_cordic_atan_quad;

    localparam int DW    = 32;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] x_in;
    logic [DW-1:0] y_in;
    logic [DW-1:0] core_x;
    logic [DW-1:0] core_y;
    logic [DW-1:0] core_atan;
    logic [DW-1:0] out_angle;

    int checks   = 0;
    int failures = 0;
    int core_pipe [LAT] = '{default: 0};

    // Inputs, expected folded operands and hand-computed angles (Q16 radians).
    int vec_x  [10] = '{655360, -655360, -655360, -65536, 0, 1310720, 0, 0, 65536, -65536};
    int vec_y  [10] = '{-1310720, 1310720, -1310720, 0, 0, 655360, 65536, -65536, 65536, -65536};
    int vec_cx [10] = '{655360, 655360, 655360, 65536, 0, 1310720, 0, 0, 65536, 65536};
    int vec_cy [10] = '{-1310720, -1310720, 1310720, 0, 0, 655360, 65536, -65536, 65536, 65536};
    int vec_a  [10] = '{-72558, 133329, -133329, 205887, 0, 30386, 102944, -102944, 51472, -154415};
    int vec_t  [10] = '{8, 8, 8, 0, 0, 8, 8, 8, 8, 8};

    always #5 clk = ~clk;

    cordic_atan_quad #(
        .DATA_WIDTH     (DW),
        .EXPAND_BIT     (16),
        .CORDIC_LATENCY (LAT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .core_x    (core_x),
        .core_y    (core_y),
        .core_atan (core_atan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle)
    );

    // Ideal core; (0,0) deliberately returns garbage the wrapper must ignore.
    function automatic int ideal_atan(input logic [DW-1:0] cx, input logic [DW-1:0] cy);
        int  xs;
        int  ys;
        real r;
        xs = $signed(cx);
        ys = $signed(cy);
        if (xs == 0 && ys == 0) begin
            return 7777;
        end else begin
            r = $atan2($itor(ys), $itor(xs)) * 65536.0;
            return int'(r);
        end
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= ideal_atan(core_x, core_y);
        for (int i = 1; i < LAT; i++) begin
            core_pipe[i] <= core_pipe[i-1];
        end
    end

    assign core_atan = core_pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert (((obs - exp) <= tol) && ((exp - obs) <= tol)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One isolated transaction: folded operands, exact latency, angle, lone result.
    task automatic run_single(input int idx, input string tag);
        chkb({tag, "_in_ready"}, in_ready, 1'b1);
        x_in     = vec_x[idx];
        y_in     = vec_y[idx];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_core_x"}, core_x, vec_cx[idx], 0);
        chk({tag, "_core_y"}, core_y, vec_cy[idx], 0);
        repeat (LAT) tick();
        chkb({tag, "_not_early"}, out_valid, 1'b0);
        tick();
        chkb({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_angle"}, out_angle, vec_a[idx], vec_t[idx]);
        tick();
        chkb({tag, "_alone"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   idx;
        int   n;
        int   held;
        logic seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        repeat (3) tick();
        chkb("rst_in_ready", in_ready, 1'b0);
        chkb("rst_out_valid", out_valid, 1'b0);
        chk("rst_core_x", core_x, 0, 0);
        chk("rst_out_angle", out_angle, 0, 0);

        rst_n = 1'b1;
        #1;
        chkb("release_in_ready_low", in_ready, 1'b0);
        tick();
        chkb("release_in_ready_high", in_ready, 1'b1);

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_single(i, $sformatf("vec%0d", i));
        end

        // Backpressure: downstream stalled, source always offering.
        out_ready = 1'b0;
        idx       = 0;
        x_in      = vec_x[0];
        y_in      = vec_y[0];
        in_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            seen = in_ready;
            tick();
            if (seen) begin
                idx++;
                if (idx < 10) begin
                    x_in = vec_x[idx];
                    y_in = vec_y[idx];
                end
            end
        end
        in_valid = 1'b0;
        chk("bp_accept_count", idx, DEPTH, 0);
        chkb("bp_in_ready_low", in_ready, 1'b0);
        held = out_angle;
        tick();
        tick();
        chkb("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_angle", out_angle, held, 0);

        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (n < 10) begin
                    chk($sformatf("drain%0d", n), out_angle, vec_a[n], vec_t[n]);
                end
                n++;
            end
            tick();
        end
        chk("drain_count", n, DEPTH, 0);
        chkb("drain_empty", out_valid, 1'b0);

        // Mid-operation reset: two buffered, three in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x_in     = vec_x[i];
            y_in     = vec_y[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 3) tick();
        chkb("pre_rst_buffered", out_valid, 1'b1);
        for (int i = 2; i < 5; i++) begin
            x_in     = vec_x[i];
            y_in     = vec_y[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chkb("midrst_out_valid", out_valid, 1'b0);
        chkb("midrst_in_ready", in_ready, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (LAT + 10) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
            end
        end
        chkb("post_rst_no_valid", seen, 1'b0);
        out_ready = 1'b1;
        run_single(9, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
